truth_table_reader: RTL and testbench

//   Sequential characteriser for small combinational logic designs such as the 3-input NOT/NOR gate netlists.

---
 rtl/ttr_pkg.sv | 17 +
 rtl/ttr_settle_timer.sv | 37 +++
 rtl/truth_table_reader.sv | 157 +++++++++++++++
 tb/tb_truth_table_reader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ttr_pkg.sv
// Shared types and helpers for the truth-table reader (truth_table_reader, ttr_settle_timer).
package ttr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } ttr_state_e;

    localparam int unsigned TTR_SETTLE_CYCLES_DEF = 4;

    function automatic int unsigned n_rows(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/ttr_settle_timer.sv
// Loadable up-counter; term_o pulses while enabled on the cycle the count reaches TERM_CNT-1.
module ttr_settle_timer #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned TERM_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             term_o
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TERM_CNT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = en_i && (cnt_q == TERM_VAL);

endmodule

// File: rtl/truth_table_reader.sv
// Sweeps all DUT input rows, samples the output per row and compares the code to an expected value.
// Optional macro TTR_STABILITY_CHECK_EN adds per-row glitch detection on the unstable port.
module truth_table_reader
    import ttr_pkg::*;
#(
    parameter  int unsigned N_IN          = 3,
    parameter  int unsigned SETTLE_CYCLES = TTR_SETTLE_CYCLES_DEF,
    parameter  int unsigned CNT_W         = 8,
    localparam int unsigned N_ROWS        = n_rows(N_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_ROWS-1:0] expected,
    output logic [N_IN-1:0]   stim,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic [N_ROWS-1:0] code,
    output logic              match,
    output logic [N_ROWS-1:0] unstable
);

    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(N_ROWS - 1);

    ttr_state_e        state_q, state_d;
    logic [N_IN-1:0]   row_q, row_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [N_ROWS-1:0] code_q, code_d;
    logic [N_ROWS-1:0] exp_q, exp_d;
    logic              match_q, match_d;
    logic              tmr_load, tmr_en, tmr_term;

`ifdef TTR_STABILITY_CHECK_EN
    logic [N_ROWS-1:0] unst_q, unst_d;
    logic              cap_q;
`endif

    ttr_settle_timer #(
        .CNT_W    (CNT_W),
        .TERM_CNT (SETTLE_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i ('0),
        .en_i       (tmr_en),
        .term_o     (tmr_term)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        stim_d   = stim_q;
        code_d   = code_q;
        exp_d    = exp_q;
        match_d  = match_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
`ifdef TTR_STABILITY_CHECK_EN
        unst_d   = unst_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d    = expected;
                    code_d   = '0;
                    match_d  = 1'b0;
                    row_d    = '0;
                    stim_d   = '0;
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
`ifdef TTR_STABILITY_CHECK_EN
                    unst_d   = '0;
`endif
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_term) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                code_d[row_q] = dut_out;
                tmr_load      = 1'b1;
`ifdef TTR_STABILITY_CHECK_EN
                if (cap_q != dut_out) begin
                    unst_d[row_q] = 1'b1;
                end
`endif
                if (row_q == LAST_ROW) begin
                    // Match is resolved on entry to DONE so it is valid alongside the done pulse.
`ifdef TTR_STABILITY_CHECK_EN
                    match_d = (code_d == exp_q) && !(|unst_d);
`else
                    match_d = (code_d == exp_q);
`endif
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    stim_d  = row_d;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            stim_q  <= '0;
            code_q  <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            stim_q  <= stim_d;
            code_q  <= code_d;
            exp_q   <= exp_d;
            match_q <= match_d;
        end
    end

`ifdef TTR_STABILITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unst_q <= '0;
            cap_q  <= 1'b0;
        end else begin
            unst_q <= unst_d;
            if ((state_q == ST_SETTLE) && tmr_term) begin
                cap_q <= dut_out;
            end
        end
    end

    assign unstable = unst_q;
`else
    assign unstable = '0;
`endif

    assign stim  = stim_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign code  = code_q;
    assign match = match_q;

endmodule

// File: tb/tb_truth_table_reader.sv
// Directed bench for truth_table_reader: table-driven sweeps plus reset, re-start, hold-start and glitch cases.
module tb_truth_table_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] expected;
    logic [2:0] stim;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic [7:0] code;
    logic       match;
    logic [7:0] unstable;

    logic [7:0] func;
    logic       glitch;

    int total;
    int bad;

    truth_table_reader #(
        .N_IN          (3),
        .SETTLE_CYCLES (4),
        .CNT_W         (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .expected (expected),
        .stim     (stim),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .code     (code),
        .match    (match),
        .unstable (unstable)
    );

    assign dut_out = func[stim] ^ glitch;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one sweep from IDLE, observes 60 cycles after the accept edge.
    task automatic do_sweep(input logic [7:0] f_in, input logic [7:0] exp_in,
                            input int pa, input int pb, input int gr,
                            output int dcyc, output int ndone);
        func     = f_in;
        expected = exp_in;
        start    = 1'b1;
        dcyc     = -1;
        ndone    = 0;
        step();
        start    = 1'b0;
        expected = ~exp_in;
        for (int c = 1; c <= 60; c++) begin
            start  = (c == pa) || (c == pb);
            glitch = (gr >= 0) && (c == 5 * gr + 5);
            if (c <= 40) chk("stim", 32'(stim), 32'((c - 1) / 5));
            chk("busy", 32'(busy), 32'(c <= 41));
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
            end
            step();
        end
        start  = 1'b0;
        glitch = 1'b0;
    endtask

    typedef struct {
        logic [7:0] f;
        logic [7:0] exp_in;
        logic [7:0] exp_code;
        logic       exp_match;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int dcyc;
        int ndone;
        int dt[3];
        int nd;
        int lowcnt;
        logic [7:0] unst_req;

        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        expected = '0;
        func     = '0;
        glitch   = 1'b0;

        vecs[0] = '{8'h46, 8'h46, 8'h46, 1'b1};
        vecs[1] = '{8'h46, 8'h47, 8'h46, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 1'b1};
        vecs[4] = '{8'hA5, 8'h5A, 8'hA5, 1'b0};
        vecs[5] = '{8'h81, 8'h81, 8'h81, 1'b1};

        #3;
        chk("rst_stim", 32'(stim), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_match", 32'(match), 0);
        chk("rst_unstable", 32'(unstable), 0);
        step();
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            do_sweep(vecs[i].f, vecs[i].exp_in, -1, -1, -1, dcyc, ndone);
            chk("done_cycle", 32'(dcyc), 41);
            chk("done_count", 32'(ndone), 1);
            chk("code", 32'(code), 32'(vecs[i].exp_code));
            chk("match", 32'(match), 32'(vecs[i].exp_match));
            chk("unstable", 32'(unstable), 0);
            chk("stim_hold", 32'(stim), 7);
        end

        // Extra start pulses mid-sweep must be ignored.
        do_sweep(8'h46, 8'h46, 5, 30, -1, dcyc, ndone);
        chk("restart_done_cycle", 32'(dcyc), 41);
        chk("restart_done_count", 32'(ndone), 1);
        chk("restart_code", 32'(code), 32'h46);
        chk("restart_match", 32'(match), 1);

        // Asynchronous reset at cycle 20 of a sweep.
        func     = 8'h46;
        expected = 8'h46;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_stim", 32'(stim), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_code", 32'(code), 0);
        chk("mid_rst_match", 32'(match), 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", 32'(busy), 0);
        do_sweep(8'h46, 8'h46, -1, -1, -1, dcyc, ndone);
        chk("post_rst_done_cycle", 32'(dcyc), 41);
        chk("post_rst_code", 32'(code), 32'h46);
        chk("post_rst_match", 32'(match), 1);

        // start held high: back-to-back sweeps.
        func     = 8'hA5;
        expected = 8'hA5;
        start    = 1'b1;
        nd       = 0;
        lowcnt   = 0;
        for (int c = 1; c <= 130; c++) begin
            step();
            if (done && nd < 3) begin
                dt[nd] = c;
                nd++;
            end
            if (!busy && nd == 1) lowcnt++;
        end
        start = 1'b0;
        chk("hold_done_count", 32'(nd), 3);
        if (nd == 3) begin
            chk("hold_first_done", 32'(dt[0]), 41);
            chk("hold_period_a", 32'(dt[1] - dt[0]), 42);
            chk("hold_period_b", 32'(dt[2] - dt[1]), 42);
        end
        chk("hold_busy_low", 32'(lowcnt), 1);
        repeat (50) step();
        chk("hold_code", 32'(code), 32'hA5);
        chk("hold_match", 32'(match), 1);
        chk("hold_idle", 32'(busy), 0);

        // Output toggles in the sample cycle of row 3.
`ifdef TTR_STABILITY_CHECK_EN
        unst_req = 8'h08;
`else
        unst_req = 8'h00;
`endif
        do_sweep(8'h46, 8'h46, -1, -1, 3, dcyc, ndone);
        chk("glitch_done_cycle", 32'(dcyc), 41);
        chk("glitch_code", 32'(code), 32'h4E);
        chk("glitch_match", 32'(match), 0);
        chk("glitch_unstable", 32'(unstable), 32'(unst_req));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
